// File: rtl/gp_engine_pkg.sv
// Shared types for the GP engine command sequencer: opcodes, error codes,
// sequencer states and command-word field positions.
package gp_engine_pkg;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 30;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_WAIT  = 2'b10,
        OP_END   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_OVERFLOW = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_ABORT    = 2'd3
    } err_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_F0,
        S_W0,
        S_F1,
        S_W1,
        S_EXEC,
        S_RESP,
        S_DELAY,
        S_DONE
    } seq_state_e;

    function automatic logic is_mst_op(input op_e op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/gp_seq_timer.sv
// Loadable down-counter shared by the DELAY countdown and the response timeouts.
// Load wins over decrement; the count saturates at zero.
module gp_seq_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/gp_cmd_sequencer.sv
// Walks the GP engine command buffer two words per command and executes
// master writes/reads, timed waits and end-of-list, reporting busy/done/error.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_F0    | fetch request for word0 (idx)
// S_W0    | waiting for word0 from buffer
// S_F1    | fetch request for word1 (idx+1)
// S_W1    | waiting for word1 from buffer
// S_EXEC  | decode; master request held here until ready
// S_RESP  | waiting for master read data
// S_DELAY | counting out a WAIT command
// S_DONE  | one-cycle done pulse
module gp_cmd_sequencer
    import gp_engine_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_WIDTH   = 8,
    parameter int RSP_TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IDX_WIDTH-1:0]  start_idx,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err_code,
    output logic [DATA_WIDTH-1:0] last_rd_data,
    output logic                  cmd_rd_en,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_rd_valid,
    input  logic [DATA_WIDTH-1:0] cmd_out,
    output logic                  mst_o_valid,
    output logic                  mst_o_rd0_wr1,
    output logic [ADDR_WIDTH-1:0] mst_o_addr,
    output logic [DATA_WIDTH-1:0] mst_o_wr_data,
    input  logic                  mst_i_ready,
    input  logic                  mst_i_rd_valid,
    input  logic [DATA_WIDTH-1:0] mst_i_rd_data
);

    localparam int TW = DATA_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = {{(IDX_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [TW-1:0] TO_LOAD = TW'(RSP_TIMEOUT - 1);

    seq_state_e            state_q, state_d;
    err_e                  err_q, err_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] word0_q, word0_d;
    logic [DATA_WIDTH-1:0] word1_q, word1_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  abort_q, abort_d;

    logic                  tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0]         tmr_val;
    op_e                   op;
    logic                  mst_req;
    logic                  abort_any;
    seq_state_e            adv_state;
    err_e                  adv_err;

    gp_seq_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    assign op        = op_e'(word0_q[OP_MSB:OP_LSB]);
    assign abort_any = abort | abort_q;

    // Moving to the next command: wrap past the last slot beats a pending abort.
    always_comb begin
        adv_state = S_F0;
        adv_err   = err_q;
        if (idx_q == LAST_IDX) begin
            adv_state = S_DONE;
            adv_err   = ERR_OVERFLOW;
        end else if (abort_any) begin
            adv_state = S_DONE;
            adv_err   = ERR_ABORT;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        idx_d     = idx_q;
        word0_d   = word0_q;
        word1_d   = word1_q;
        rd_data_d = rd_data_q;
        abort_d   = abort_q;
        tmr_load  = 1'b0;
        tmr_val   = TO_LOAD;
        tmr_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = {start_idx[IDX_WIDTH-1:1], 1'b0};
                    err_d   = ERR_OK;
                    abort_d = 1'b0;
                    state_d = S_F0;
                end
            end
            S_F0, S_F1: begin
                if (abort) begin
                    state_d = S_DONE;
                    err_d   = ERR_ABORT;
                end else begin
                    state_d  = (state_q == S_F0) ? S_W0 : S_W1;
                    tmr_load = 1'b1;
                end
            end
            S_W0, S_W1: begin
                if (!cmd_rd_valid && tmr_zero) begin
                    state_d = S_DONE;
                    err_d   = ERR_TIMEOUT;
                end else if (abort) begin
                    state_d = S_DONE;
                    err_d   = ERR_ABORT;
                end else if (cmd_rd_valid) begin
                    if (state_q == S_W0) begin
                        word0_d = cmd_out;
                        state_d = S_F1;
                    end else begin
                        word1_d  = cmd_out;
                        state_d  = S_EXEC;
                        tmr_load = 1'b1;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_EXEC: begin
                if (op == OP_END) begin
                    state_d = S_DONE;
                    if (abort) err_d = ERR_ABORT;
                end else if (op == OP_WAIT) begin
                    if (word1_q == '0) begin
                        state_d = adv_state;
                        err_d   = adv_err;
                        idx_d   = idx_q + IDX_WIDTH'(2);
                    end else if (abort) begin
                        state_d = S_DONE;
                        err_d   = ERR_ABORT;
                    end else begin
                        state_d  = S_DELAY;
                        tmr_load = 1'b1;
                        tmr_val  = word1_q - TW'(1);
                    end
                end else if (mst_i_ready) begin
                    if (op == OP_WRITE) begin
                        state_d = adv_state;
                        err_d   = adv_err;
                        idx_d   = idx_q + IDX_WIDTH'(2);
                    end else if (abort_any) begin
                        state_d = S_DONE;
                        err_d   = ERR_ABORT;
                    end else begin
                        state_d  = S_RESP;
                        tmr_load = 1'b1;
                    end
                end else if (tmr_zero) begin
                    state_d = S_DONE;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    tmr_en = 1'b1;
                    if (abort) abort_d = 1'b1;
                end
            end
            S_RESP: begin
                if (!mst_i_rd_valid && tmr_zero) begin
                    state_d = S_DONE;
                    err_d   = ERR_TIMEOUT;
                end else if (mst_i_rd_valid) begin
                    rd_data_d = mst_i_rd_data;
                    state_d   = adv_state;
                    err_d     = adv_err;
                    idx_d     = idx_q + IDX_WIDTH'(2);
                end else if (abort) begin
                    state_d = S_DONE;
                    err_d   = ERR_ABORT;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_DELAY: begin
                if (tmr_zero) begin
                    state_d = adv_state;
                    err_d   = adv_err;
                    idx_d   = idx_q + IDX_WIDTH'(2);
                end else if (abort) begin
                    state_d = S_DONE;
                    err_d   = ERR_ABORT;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            err_q     <= ERR_OK;
            idx_q     <= '0;
            word0_q   <= '0;
            word1_q   <= '0;
            rd_data_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            word0_q   <= word0_d;
            word1_q   <= word1_d;
            rd_data_q <= rd_data_d;
            abort_q   <= abort_d;
        end
    end

    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign err_code     = err_q;
    assign last_rd_data = rd_data_q;

    assign cmd_rd_en = (state_q == S_F0) || (state_q == S_F1);

    always_comb begin
        cmd_addr = '0;
        if (state_q == S_F0) begin
            cmd_addr = ADDR_WIDTH'(idx_q);
        end else if (state_q == S_F1) begin
            cmd_addr = ADDR_WIDTH'({idx_q[IDX_WIDTH-1:1], 1'b1});
        end
    end

    // Request fields are gated so the bus reads all-zero whenever no request is up.
    assign mst_req       = (state_q == S_EXEC) && is_mst_op(op);
    assign mst_o_valid   = mst_req;
    assign mst_o_rd0_wr1 = mst_req && (op == OP_WRITE);
    assign mst_o_addr    = mst_req ? ADDR_WIDTH'(word0_q[OP_LSB-1:0]) : '0;
    assign mst_o_wr_data = (mst_req && (op == OP_WRITE)) ? word1_q : '0;

endmodule
